// File: rtl/viterbi_chan_pkg.sv
// Shared types and helpers for the Viterbi test-harness bit-error channel.
package viterbi_chan_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_RANDOM = 2'd1,
      MODE_BURST  = 2'd2,
      MODE_FIXED  = 2'd3
   } chan_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } chan_state_e;

   localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

   // Galois taps for the supported generator widths; 32 is the reference width.
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         8:       lfsr_taps = 32'h0000_00B8;
         16:      lfsr_taps = 32'h0000_B400;
         24:      lfsr_taps = 32'h00E1_0000;
         default: lfsr_taps = LFSR_TAPS_32;
      endcase
   endfunction

   function automatic logic [31:0] popcount(input logic [31:0] v);
      popcount = '0;
      for (int i = 0; i < 32; i++) popcount = popcount + 32'(v[i]);
   endfunction

endpackage

// File: rtl/viterbi_chan_lfsr.sv
// Right-shifting Galois LFSR that steps once per asserted adv.
module viterbi_chan_lfsr
   import viterbi_chan_pkg::*;
#(
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   output logic [LFSR_W-1:0] state
);

   localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
   // An all-zero state would lock the generator up.
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (adv) state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= SEED_EFF;
      else      state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/viterbi_channel_model.sv
// Bit-error channel between convolutional encoder and Viterbi decoder: a one-cycle
// registered path that XORs a mode-selected error mask onto each valid symbol.
module viterbi_channel_model
   import viterbi_chan_pkg::*;
#(
   parameter int                SYM_W     = 2,
   parameter int                N         = 3,
   parameter int                MAX_BURST = 8,
   parameter int                LFSR_W    = 32,
   parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(32'h1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [SYM_W-1:0] sym_i,
   input  logic [1:0]       mode_i,
   input  logic             inj_en_i,
   input  logic             force_i,
   input  logic [7:0]       burst_len_i,
   input  logic [SYM_W-1:0] err_mask_i,
   input  logic             clr_cnt_i,
   output logic             valid_o,
   output logic [SYM_W-1:0] sym_o,
   output logic [SYM_W-1:0] clean_o,
   output logic             err_o,
   output logic [31:0]      sym_ct_o,
   output logic [31:0]      err_bit_ct_o
);

   localparam logic [7:0] MAXB = 8'(MAX_BURST);

   logic [LFSR_W-1:0] lfsr;
   logic              lfsr_unused;
   chan_mode_e        mode;
   logic              inj_on, force_eff, trig;
   logic              pend_q, pend_d;
   chan_state_e       state_q, state_d;
   logic [7:0]        cnt_q, cnt_d, blen_c;
   logic [SYM_W-1:0]  rnd_bits, mask;
   logic              valid_q, err_q;
   logic [SYM_W-1:0]  sym_q, clean_q;
   logic [31:0]       sym_ct_q, sym_ct_d, ebit_ct_q, ebit_ct_d;
   logic [32:0]       ebit_sum;

   viterbi_chan_lfsr #(
      .LFSR_W (LFSR_W),
      .SEED   (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .adv   (valid_i),
      .state (lfsr)
   );

   assign lfsr_unused = ^lfsr[LFSR_W-1:N+SYM_W];
   assign mode        = chan_mode_e'(mode_i);
   assign inj_on      = inj_en_i && (mode != MODE_OFF);
   assign force_eff   = inj_on && (force_i || pend_q);
   assign trig        = (&lfsr[N-1:0]) || force_eff;
   assign rnd_bits    = lfsr[N +: SYM_W];
   assign blen_c      = (burst_len_i == 8'd0) ? 8'd1 :
                        (burst_len_i > MAXB)  ? MAXB : burst_len_i;

   // A force seen on a bubble waits for the next valid symbol; any valid symbol consumes it.
   always_comb begin
      pend_d = pend_q;
      if (!inj_on)      pend_d = 1'b0;
      else if (valid_i) pend_d = 1'b0;
      else if (force_i) pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // cnt_q holds the corrupted symbols still owed after the current one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mode != MODE_BURST || !inj_en_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (valid_i) begin
         case (state_q)
            ST_IDLE: begin
               if (trig && blen_c > 8'd1) begin
                  state_d = ST_BURST;
                  cnt_d   = blen_c - 8'd1;
               end
            end
            ST_BURST: begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      mask = '0;
      if (inj_en_i) begin
         case (mode)
            MODE_RANDOM: if (trig) mask = (rnd_bits == '0) ? SYM_W'(1) : rnd_bits;
            MODE_BURST:  if (state_q == ST_BURST || trig) mask = err_mask_i;
            MODE_FIXED:  if (&sym_ct_q[N-1:0]) mask = err_mask_i;
            default:     mask = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         sym_q   <= '0;
         clean_q <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            sym_q   <= sym_i ^ mask;
            clean_q <= sym_i;
            err_q   <= (mask != '0);
         end
      end
   end

   assign ebit_sum = {1'b0, ebit_ct_q} + {1'b0, popcount(32'(mask))};

   // Clear wins over a coincident symbol, which then goes uncounted.
   always_comb begin
      sym_ct_d  = sym_ct_q;
      ebit_ct_d = ebit_ct_q;
      if (clr_cnt_i) begin
         sym_ct_d  = '0;
         ebit_ct_d = '0;
      end else if (valid_i) begin
         if (~&sym_ct_q) sym_ct_d = sym_ct_q + 32'd1;
         ebit_ct_d = ebit_sum[32] ? '1 : ebit_sum[31:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_ct_q  <= '0;
         ebit_ct_q <= '0;
      end else begin
         sym_ct_q  <= sym_ct_d;
         ebit_ct_q <= ebit_ct_d;
      end
   end

   assign valid_o      = valid_q;
   assign sym_o        = sym_q;
   assign clean_o      = clean_q;
   assign err_o        = err_q;
   assign sym_ct_o     = sym_ct_q;
   assign err_bit_ct_o = ebit_ct_q;

endmodule

// File: tb/tb_viterbi_channel_model.sv
// Scoreboard bench: stimulus feeds a behavioural channel model that queues expected
// outputs; a negedge monitor pops and compares whenever valid_o appears.
module tb_viterbi_channel_model;

   localparam int SYM_W     = 2;
   localparam int N         = 3;
   localparam int MAX_BURST = 8;
   localparam int PH        = (1 << N) - 1;
   localparam int SM        = (1 << SYM_W) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [1:0]  sym_i = '0, mode_i = '0, err_mask_i = '0;
   logic        inj_en_i = 1'b0, force_i = 1'b0, clr_cnt_i = 1'b0;
   logic [7:0]  burst_len_i = '0;
   logic        valid_o, err_o;
   logic [1:0]  sym_o, clean_o;
   logic [31:0] sym_ct_o, err_bit_ct_o;

   always #5 clk = ~clk;

   viterbi_channel_model #(
      .SYM_W(SYM_W), .N(N), .MAX_BURST(MAX_BURST), .LFSR_W(32), .SEED(32'h1)
   ) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
      .inj_en_i(inj_en_i), .force_i(force_i), .burst_len_i(burst_len_i),
      .err_mask_i(err_mask_i), .clr_cnt_i(clr_cnt_i), .valid_o(valid_o),
      .sym_o(sym_o), .clean_o(clean_o), .err_o(err_o), .sym_ct_o(sym_ct_o),
      .err_bit_ct_o(err_bit_ct_o)
   );

   typedef struct {
      logic [1:0]  sym;
      logic [1:0]  clean;
      logic        err;
      logic [31:0] sct;
      logic [31:0] ebc;
      int          stamp;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          n_chk = 0, n_fail = 0, cyc = 0, err_syms = 0;
   bit          mon_en = 1'b0;
   logic [1:0]  last_sym = '0, last_clean = '0;

   // Reference channel state
   logic [31:0] m_lfsr;
   bit          m_pend;
   int          m_rem;
   longint      m_sct, m_ebc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mon_en) begin
         if (valid_o) begin
            if (q.size() == 0) begin
               chk("unexpected_valid_o", 32'(valid_o), 32'd0);
            end else begin
               me = q.pop_front();
               chk("latency", 32'(cyc), 32'(me.stamp));
               chk("sym_o", 32'(sym_o), 32'(me.sym));
               chk("clean_o", 32'(clean_o), 32'(me.clean));
               chk("err_o", 32'(err_o), 32'(me.err));
               chk("sym_ct_o", sym_ct_o, me.sct);
               chk("err_bit_ct_o", err_bit_ct_o, me.ebc);
               last_sym   = me.sym;
               last_clean = me.clean;
               if (err_o) err_syms++;
            end
         end else begin
            if (q.size() != 0 && q[0].stamp <= cyc) begin
               chk("missing_valid_o", 32'(valid_o), 32'd1);
               void'(q.pop_front());
            end
            chk("sym_o_hold", 32'(sym_o), 32'(last_sym));
            chk("clean_o_hold", 32'(clean_o), 32'(last_clean));
         end
      end
   end

   // Channel rules expressed per cycle: mask choice, burst budget, force latch, stats.
   task automatic model(input bit v, input logic [1:0] s, input logic [1:0] md, input bit inj,
                        input bit frc, input logic [7:0] bl, input logic [1:0] em, input bit clr);
      bit   on, fe, trig;
      int   msk, len;
      exp_t e;
      on   = inj && (md != 2'd0);
      fe   = on && (frc || m_pend);
      trig = ((m_lfsr & PH) == PH) || fe;
      msk  = 0;
      if (on) begin
         if (md == 2'd1 && trig) begin
            msk = int'((m_lfsr >> N) & SM);
            if (msk == 0) msk = 1;
         end
         if (md == 2'd2 && (m_rem > 0 || trig)) msk = int'(em);
         if (md == 2'd3 && (m_sct % (1 << N)) == PH) msk = int'(em);
      end
      if (md != 2'd2 || !inj) m_rem = 0;
      else if (v) begin
         if (m_rem > 0) m_rem--;
         else if (trig) begin
            len   = (bl == 0) ? 1 : ((bl > MAX_BURST) ? MAX_BURST : int'(bl));
            m_rem = len - 1;
         end
      end
      if (!on || v) m_pend = 1'b0;
      else if (frc) m_pend = 1'b1;
      if (v) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
      if (clr) begin
         m_sct = 0;
         m_ebc = 0;
      end else if (v) begin
         m_sct = (m_sct >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sct + 1;
         m_ebc = m_ebc + $countones(msk);
         if (m_ebc > 64'hFFFF_FFFF) m_ebc = 64'hFFFF_FFFF;
      end
      if (v) begin
         e.sym   = s ^ msk[1:0];
         e.clean = s;
         e.err   = (msk != 0);
         e.sct   = m_sct[31:0];
         e.ebc   = m_ebc[31:0];
         e.stamp = cyc + 1;
         q.push_back(e);
      end
   endtask

   task automatic drv(input bit v, input logic [1:0] s, input logic [1:0] md, input bit inj,
                      input bit frc, input logic [7:0] bl, input logic [1:0] em, input bit clr);
      valid_i = v; sym_i = s; mode_i = md; inj_en_i = inj; force_i = frc;
      burst_len_i = bl; err_mask_i = em; clr_cnt_i = clr;
      model(v, s, md, inj, frc, bl, em, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, sym_i, mode_i, inj_en_i, 1'b0, burst_len_i, err_mask_i, 1'b0);
   endtask

   // Asserted off-edge, so outputs must be zero before any clock arrives.
   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b0;
      valid_i = 1'b0; sym_i = '0; mode_i = '0; inj_en_i = 1'b0; force_i = 1'b0;
      burst_len_i = '0; err_mask_i = '0; clr_cnt_i = 1'b0;
      #1;
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_sym_o", 32'(sym_o), 32'd0);
      chk("rst_clean_o", 32'(clean_o), 32'd0);
      chk("rst_err_o", 32'(err_o), 32'd0);
      chk("rst_sym_ct_o", sym_ct_o, 32'd0);
      chk("rst_err_bit_ct_o", err_bit_ct_o, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      m_lfsr = 32'h1; m_pend = 1'b0; m_rem = 0; m_sct = 0; m_ebc = 0;
      last_sym = '0; last_clean = '0;
      mon_en = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      do_reset();

      // OFF mode: transparent channel
      for (int i = 0; i < 16; i++) drv(1'b1, 2'b10, 2'd0, 1'b1, 1'b0, 8'd0, 2'b11, 1'b0);
      idle(2);
      chk("off_sym_ct", sym_ct_o, 32'd16);
      chk("off_err_bits", err_bit_ct_o, 32'd0);

      // FIXED: period 8, hits symbols 7 and 15
      do_reset();
      for (int i = 0; i < 16; i++) drv(1'b1, 2'b00, 2'd3, 1'b1, 1'b0, 8'd0, 2'b11, 1'b0);
      idle(2);
      chk("fixed_err_bits", err_bit_ct_o, 32'd4);

      // BURST from force, lengths 3 and 0
      for (int r = 0; r < 2; r++) begin
         do_reset();
         for (int i = 0; i < 16; i++) begin
            if (i == 5) drv(1'b0, 2'b00, 2'd2, 1'b1, 1'b1, (r == 0) ? 8'd3 : 8'd0, 2'b01, 1'b0);
            drv(1'b1, 2'b00, 2'd2, 1'b1, 1'b0, (r == 0) ? 8'd3 : 8'd0, 2'b01, 1'b0);
         end
         idle(2);
         chk("burst_err_bits", err_bit_ct_o, m_ebc[31:0]);
      end

      // Abort a max-length burst by dropping inj_en_i, then reset mid-burst
      do_reset();
      for (int i = 0; i < 3; i++) drv(1'b1, 2'b10, 2'd2, 1'b1, 1'b0, 8'd8, 2'b11, 1'b0);
      drv(1'b0, 2'b10, 2'd2, 1'b1, 1'b1, 8'd8, 2'b11, 1'b0);
      for (int i = 0; i < 2; i++) drv(1'b1, 2'b10, 2'd2, 1'b1, 1'b0, 8'd8, 2'b11, 1'b0);
      for (int i = 0; i < 3; i++) drv(1'b1, 2'b10, 2'd2, 1'b0, 1'b0, 8'd8, 2'b11, 1'b0);
      for (int i = 0; i < 4; i++) drv(1'b1, 2'b10, 2'd2, 1'b1, 1'b0, 8'd8, 2'b11, 1'b0);
      drv(1'b0, 2'b10, 2'd2, 1'b1, 1'b1, 8'd8, 2'b11, 1'b0);
      for (int i = 0; i < 2; i++) drv(1'b1, 2'b01, 2'd2, 1'b1, 1'b0, 8'd8, 2'b11, 1'b0);
      do_reset();

      // RANDOM: 4096 valid symbols with sprinkled bubbles
      err_syms = 0;
      nv = 0;
      while (nv < 4096) begin
         if ($urandom_range(7) == 0) drv(1'b0, 2'(sym_i), 2'd1, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0);
         else begin
            drv(1'b1, 2'($urandom), 2'd1, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0);
            nv++;
         end
      end
      idle(2);
      chk("random_sym_ct", sym_ct_o, 32'd4096);
      chk("random_rate_in_window", 32'(err_syms >= 448 && err_syms <= 576), 32'd1);

      // clr_cnt_i together with a valid symbol restarts stats and the fixed phase
      do_reset();
      for (int i = 0; i < 10; i++) drv(1'b1, 2'b00, 2'd3, 1'b1, 1'b0, 8'd0, 2'b10, 1'b0);
      drv(1'b1, 2'b00, 2'd3, 1'b1, 1'b0, 8'd0, 2'b10, 1'b1);
      chk("clr_sym_ct", sym_ct_o, 32'd0);
      chk("clr_err_bits", err_bit_ct_o, 32'd0);
      for (int i = 0; i < 16; i++) drv(1'b1, 2'b00, 2'd3, 1'b1, 1'b0, 8'd0, 2'b10, 1'b0);
      idle(1);
      chk("clr_fixed_restart", err_bit_ct_o, 32'd2);

      // Mixed soak: random modes, enables, forces, lengths and clears
      do_reset();
      mode_i = 2'd2;
      inj_en_i = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         drv(($urandom_range(3) != 0),
             2'($urandom),
             ($urandom_range(19) == 0) ? 2'($urandom) : mode_i,
             ($urandom_range(29) == 0) ? ~inj_en_i : inj_en_i,
             ($urandom_range(9) == 0),
             8'($urandom_range(12)),
             2'($urandom),
             ($urandom_range(63) == 0));
      end
      idle(3);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
